// File: rtl/code_to_bcd_decoder.sv
// Decodes a 3-digit coded word (E3 / 2-of-5 74210 / 2-of-5 63210) into BCD, one digit per cycle, then range-checks.
// Latency: out_valid_o rises 4 edges after accept; backpressure: result held in DONE until out_ready_i, in_ready_o low outside IDLE.
module code_to_bcd_decoder #(
   parameter bit         CHECK_RANGE = 1'b1,
   parameter logic [3:0] ERR_NIBBLE  = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [1:0]  code_sel_i,
   input  logic [14:0] code_in_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [11:0] bcd_out_o,
   output logic [2:0]  err_digit_o,
   output logic        range_err_o
);

   typedef enum logic [2:0] {IDLE, DEC2, DEC1, DEC0, CHK, DONE} state_e;

   state_e      state_q;
   logic [1:0]  sel_q;
   logic [14:0] code_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic [11:0] bcd_q;
   logic [2:0]  err_q;
   logic        range_err_q;

   logic [4:0]  cur_code;
   logic [4:0]  digit_res;
   logic [9:0]  value;
   logic        out_of_band;

   // Returns {invalid, nibble} for one coded digit under the given code selection.
   function automatic logic [4:0] dec_digit(input logic [1:0] sel, input logic [4:0] c);
      logic [4:0] r;
      logic [4:0] t;
      r = {1'b1, ERR_NIBBLE};
      t = c - 5'd3;
      case (sel)
         2'd0: if (c >= 5'd3 && c <= 5'd12) r = {1'b0, t[3:0]};
         2'd1: begin
            case (c)
               5'b11000: r = {1'b0, 4'd0};
               5'b00011: r = {1'b0, 4'd1};
               5'b00101: r = {1'b0, 4'd2};
               5'b00110: r = {1'b0, 4'd3};
               5'b01001: r = {1'b0, 4'd4};
               5'b01010: r = {1'b0, 4'd5};
               5'b01100: r = {1'b0, 4'd6};
               5'b10001: r = {1'b0, 4'd7};
               5'b10010: r = {1'b0, 4'd8};
               5'b10100: r = {1'b0, 4'd9};
               default:  r = {1'b1, ERR_NIBBLE};
            endcase
         end
         2'd2: begin
            case (c)
               5'b00110: r = {1'b0, 4'd0};
               5'b00011: r = {1'b0, 4'd1};
               5'b00101: r = {1'b0, 4'd2};
               5'b01001: r = {1'b0, 4'd3};
               5'b01010: r = {1'b0, 4'd4};
               5'b01100: r = {1'b0, 4'd5};
               5'b10001: r = {1'b0, 4'd6};
               5'b10010: r = {1'b0, 4'd7};
               5'b10100: r = {1'b0, 4'd8};
               5'b11000: r = {1'b0, 4'd9};
               default:  r = {1'b1, ERR_NIBBLE};
            endcase
         end
         default: r = {1'b1, ERR_NIBBLE};
      endcase
      return r;
   endfunction

   always_comb begin
      cur_code = code_q[4:0];
      case (state_q)
         DEC2:    cur_code = code_q[14:10];
         DEC1:    cur_code = code_q[9:5];
         default: cur_code = code_q[4:0];
      endcase
   end

   assign digit_res = dec_digit(sel_q, cur_code);

   always_comb begin
      value = {6'd0, bcd_q[11:8]} * 10'd100 + {6'd0, bcd_q[7:4]} * 10'd10 + {6'd0, bcd_q[3:0]};
      case (sel_q)
         2'd0:    out_of_band = (value > 10'd99);
         2'd1:    out_of_band = (value < 10'd100) || (value > 10'd449);
         2'd2:    out_of_band = (value < 10'd450) || (value > 10'd899);
         default: out_of_band = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= 2'd0;
         code_q      <= 15'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         bcd_q       <= 12'd0;
         err_q       <= 3'd0;
         range_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // in_ready_q is low only on the first cycle out of reset.
               if (in_ready_q && in_valid_i) begin
                  state_q     <= DEC2;
                  sel_q       <= code_sel_i;
                  code_q      <= code_in_i;
                  in_ready_q  <= 1'b0;
                  bcd_q       <= 12'd0;
                  err_q       <= 3'd0;
                  range_err_q <= 1'b0;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            DEC2: begin
               bcd_q[11:8] <= digit_res[3:0];
               err_q[2]    <= digit_res[4];
               state_q     <= DEC1;
            end
            DEC1: begin
               bcd_q[7:4] <= digit_res[3:0];
               err_q[1]   <= digit_res[4];
               state_q    <= DEC0;
            end
            DEC0: begin
               bcd_q[3:0] <= digit_res[3:0];
               err_q[0]   <= digit_res[4];
               state_q    <= CHK;
            end
            CHK: begin
               range_err_q <= CHECK_RANGE && (err_q == 3'd0) && out_of_band;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign bcd_out_o   = bcd_q;
   assign err_digit_o = err_q;
   assign range_err_o = range_err_q;

endmodule

// File: tb/tb_code_to_bcd_decoder.sv
// Scoreboard bench for code_to_bcd_decoder: directed words push expected results, a monitor pops on each output handshake.
module tb_code_to_bcd_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  code_sel = 2'd0;
   logic [14:0] code_in = 15'd0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, range_err;
   logic [11:0] bcd;
   logic [2:0]  err_digit;
   logic        nr_in_ready, nr_out_valid, nr_range_err;
   logic [11:0] nr_bcd;
   logic [2:0]  nr_err_digit;

   typedef struct {
      logic [11:0] bcd;
      logic [2:0]  err;
      logic        rng;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   code_to_bcd_decoder #(.CHECK_RANGE(1'b1), .ERR_NIBBLE(4'hF)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .code_sel_i(code_sel), .code_in_i(code_in), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .bcd_out_o(bcd), .err_digit_o(err_digit),
      .range_err_o(range_err)
   );

   code_to_bcd_decoder #(.CHECK_RANGE(1'b0), .ERR_NIBBLE(4'hF)) dut_nr (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(nr_in_ready),
      .code_sel_i(code_sel), .code_in_i(code_in), .out_valid_o(nr_out_valid),
      .out_ready_i(out_ready), .bcd_out_o(nr_bcd), .err_digit_o(nr_err_digit),
      .range_err_o(nr_range_err)
   );

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: compare on every output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 12'd1, 12'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("bcd", bcd, e.bcd);
            check("err_digit", {9'd0, err_digit}, {9'd0, e.err});
            check("range_err", {11'd0, range_err}, {11'd0, e.rng});
            check("nr_valid", {11'd0, nr_out_valid}, 12'd1);
            check("nr_bcd", nr_bcd, e.bcd);
            check("nr_err_digit", {9'd0, nr_err_digit}, {9'd0, e.err});
            check("nr_range_err", {11'd0, nr_range_err}, 12'd0);
         end
      end
   end

   // Issue one word; input is scrambled right after the accept edge to prove it is latched.
   task automatic send(input logic [1:0] sel, input logic [14:0] code,
                       input logic [11:0] e_bcd, input logic [2:0] e_err, input logic e_rng);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 12'd0, 12'd1);
      e.bcd = e_bcd;
      e.err = e_err;
      e.rng = e_rng;
      exp_q.push_back(e);
      code_sel = sel;
      code_in  = code;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      code_in  = ~code;
      code_sel = ~sel;
   endtask

   initial begin
      int n;
      #2;
      check("rst_in_ready", {11'd0, in_ready}, 12'd0);
      check("rst_out_valid", {11'd0, out_valid}, 12'd0);
      check("rst_bcd", bcd, 12'd0);
      check("rst_err", {9'd0, err_digit}, 12'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", {11'd0, in_ready}, 12'd1);

      // Latency: out_valid expected on the 4th edge after accept.
      send(2'd0, 15'b00011_00111_01000, 12'h045, 3'b000, 1'b0);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", n[11:0], 12'd4);

      send(2'd1, 15'b00101_10001_00110, 12'h273, 3'b000, 1'b0);
      send(2'd2, 15'b10001_00110_10100, 12'h608, 3'b000, 1'b0);
      send(2'd1, 15'b00011_11111_00011, 12'h1F1, 3'b010, 1'b0);
      send(2'd3, 15'b00011_00101_00110, 12'hFFF, 3'b111, 1'b0);
      send(2'd0, 15'b00100_00101_00110, 12'h123, 3'b000, 1'b1);
      send(2'd0, 15'b00011_01100_01100, 12'h099, 3'b000, 1'b0);
      send(2'd0, 15'b01101_00010_00011, 12'hFF0, 3'b110, 1'b0);
      send(2'd1, 15'b01001_01001_10100, 12'h449, 3'b000, 1'b0);
      send(2'd1, 15'b01001_01010_11000, 12'h450, 3'b000, 1'b1);
      send(2'd2, 15'b01010_01010_11000, 12'h449, 3'b000, 1'b1);
      send(2'd2, 15'b01001_01010_11000, 12'h349, 3'b000, 1'b1);

      // Backpressure: result must hold for 10 cycles with out_ready low.
      @(negedge clk);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      out_ready = 1'b0;
      send(2'd2, 15'b10001_00110_10100, 12'h608, 3'b000, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (10) begin
         @(negedge clk);
         check("hold_valid", {11'd0, out_valid}, 12'd1);
         check("hold_bcd", bcd, 12'h608);
         check("hold_in_ready", {11'd0, in_ready}, 12'd0);
      end
      out_ready = 1'b1;

      // Reset in DEC1 aborts the word.
      send(2'd1, 15'b00101_10001_00110, 12'h273, 3'b000, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("abort_bcd", bcd, 12'd0);
      check("abort_valid", {11'd0, out_valid}, 12'd0);
      check("abort_in_ready", {11'd0, in_ready}, 12'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_abort", {11'd0, in_ready}, 12'd1);
      send(2'd2, 15'b10001_00110_10100, 12'h608, 3'b000, 1'b0);

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 12'd0);
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
